// File: rtl/fx3_packet_reader.sv
// Burst-reads one buffered packet from the sample FIFO and presents it on the FX3
// slave-FIFO bus, with the write strobe and end-of-packet marker delayed to match FIFO read latency.
module fx3_packet_reader #(
    parameter int PACKET_WORDS = 8192,
    parameter int READ_LATENCY = 2
) (
    input  logic        fx3_clock,
    input  logic        nReset,
    input  logic        collectData,
    input  logic        dataAvailable,
    input  logic        bufferError,
    input  logic [15:0] fifoData,
    input  logic        fx3Ready,
    output logic        readData,
    output logic        fx3Write,
    output logic [15:0] fx3Data,
    output logic        fx3EndOfPacket,
    output logic        busy,
    output logic        errorSticky,
    output logic [15:0] packetCount
);

    localparam int CW = $clog2(PACKET_WORDS + 1);
    localparam logic [CW-1:0] LAST_WORD  = CW'(PACKET_WORDS - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ARMED, BURST, DRAIN} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           count;
    logic                    read_q;
    logic                    error_q;
    logic [15:0]             packet_count;
    logic [READ_LATENCY-1:0] write_pipe;
    logic [READ_LATENCY-1:0] eop_pipe;
    logic                    start;
    logic                    last_word;

    // The FX3 buffer is only qualified here; once a burst starts it always runs to completion.
    assign start     = dataAvailable && fx3Ready && !error_q && collectData;
    assign last_word = (state == BURST) && (count == LAST_WORD);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (collectData) state_next = ARMED;
            ARMED: begin
                if (!collectData) state_next = IDLE;
                else if (start)   state_next = BURST;
            end
            BURST:   if (last_word) state_next = DRAIN;
            DRAIN:   if (count == LAST_DRAIN) state_next = collectData ? ARMED : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fx3_clock or negedge nReset) begin
        if (!nReset) begin
            state  <= IDLE;
            count  <= '0;
            read_q <= 1'b0;
        end else begin
            state  <= state_next;
            read_q <= (state_next == BURST);
            // One counter serves both the word count in BURST and the latency count in DRAIN.
            if (state_next != state)
                count <= '0;
            else if (state == BURST || state == DRAIN)
                count <= count + CW'(1);
        end
    end

    // The pipeline is cleared on reset so an aborted burst never emits a stray write or EOP.
    always_ff @(posedge fx3_clock or negedge nReset) begin
        if (!nReset) begin
            write_pipe <= '0;
            eop_pipe   <= '0;
        end else begin
            write_pipe[0] <= read_q;
            eop_pipe[0]   <= last_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                write_pipe[i] <= write_pipe[i-1];
                eop_pipe[i]   <= eop_pipe[i-1];
            end
        end
    end

    always_ff @(posedge fx3_clock or negedge nReset) begin
        if (!nReset) begin
            packet_count <= '0;
            error_q      <= 1'b0;
        end else begin
            if (eop_pipe[READ_LATENCY-1])
                packet_count <= packet_count + 16'd1;
            // Dropping collectData is the host's acknowledge, so it overrides a coincident error.
            if (!collectData)
                error_q <= 1'b0;
            else if (bufferError)
                error_q <= 1'b1;
        end
    end

    assign readData       = read_q;
    assign fx3Write       = write_pipe[READ_LATENCY-1];
    assign fx3EndOfPacket = eop_pipe[READ_LATENCY-1];
    assign fx3Data        = fifoData;
    assign busy           = (state == BURST) || (state == DRAIN);
    assign errorSticky    = error_q;
    assign packetCount    = packet_count;

endmodule

// File: tb/tb_fx3_packet_reader.sv
// Self-checking bench for fx3_packet_reader: a ramp FIFO model feeds the reader and a
// negedge monitor scores the bus against packet/latency rules; each scenario task checks its results.
module tb_fx3_packet_reader;

    localparam int P = 8192;
    localparam int L = 2;

    logic        fx3_clock = 1'b0;
    logic        n_reset;
    logic        collect_data;
    logic        data_available;
    logic        buffer_error;
    logic [15:0] fifo_data;
    logic        fx3_ready;
    logic        read_data;
    logic        fx3_write;
    logic [15:0] fx3_data;
    logic        fx3_eop;
    logic        busy;
    logic        error_sticky;
    logic [15:0] packet_count;

    fx3_packet_reader #(.PACKET_WORDS(P), .READ_LATENCY(L)) dut (
        .fx3_clock      (fx3_clock),
        .nReset         (n_reset),
        .collectData    (collect_data),
        .dataAvailable  (data_available),
        .bufferError    (buffer_error),
        .fifoData       (fifo_data),
        .fx3Ready       (fx3_ready),
        .readData       (read_data),
        .fx3Write       (fx3_write),
        .fx3Data        (fx3_data),
        .fx3EndOfPacket (fx3_eop),
        .busy           (busy),
        .errorSticky    (error_sticky),
        .packetCount    (packet_count)
    );

    always #5 fx3_clock = ~fx3_clock;

    int cyc = 0;
    always @(posedge fx3_clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Monitor / reference model state
    logic [15:0] base;
    int hist[L];
    int rd_idx, wr_idx;
    logic prev_rd;
    int rd_cnt, wr_cnt, eop_cnt, data_bad, eop_bad, busy_bad;
    int rd_rise[$];
    int rd_fall[$];
    int eop_cyc[$];
    int pc_at_eop[$];

    function automatic int at_or(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Sampled on the falling edge; the FIFO model then sets the word for the next cycle:
    // a word read in cycle r is on fifo_data during cycle r+L.
    always @(negedge fx3_clock) begin
        logic want_eop;
        want_eop = 1'b0;
        if (fx3_eop) begin
            eop_cnt++;
            eop_cyc.push_back(cyc);
            pc_at_eop.push_back(int'(packet_count));
        end
        if (!n_reset) begin
            for (int i = 0; i < L; i++) hist[i] = -1;
            rd_idx    = 0;
            wr_idx    = 0;
            prev_rd   = 1'b0;
            fifo_data = 16'h5a5a;
        end else begin
            if (read_data) begin
                rd_cnt++;
                if (!prev_rd) rd_rise.push_back(cyc);
            end else if (prev_rd) begin
                rd_fall.push_back(cyc - 1);
            end
            prev_rd = read_data;
            if (fx3_write) begin
                if (fx3_data !== base + 16'(wr_idx)) data_bad++;
                want_eop = ((wr_idx % P) == P - 1);
                wr_idx++;
                wr_cnt++;
            end
            if (fx3_eop !== want_eop) eop_bad++;
            if (busy !== (read_data | fx3_write)) busy_bad++;
            for (int i = L - 1; i > 0; i--) hist[i] = hist[i-1];
            if (read_data) begin
                hist[0] = rd_idx;
                rd_idx++;
            end else begin
                hist[0] = -1;
            end
            if (hist[L-1] >= 0) fifo_data = base + 16'(hist[L-1]);
            else                fifo_data = base + 16'(rd_idx) + 16'h8000;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge fx3_clock);
        #2;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; eop_cnt = 0;
        data_bad = 0; eop_bad = 0; busy_bad = 0;
        rd_rise.delete(); rd_fall.delete(); eop_cyc.delete(); pc_at_eop.delete();
    endtask

    task automatic apply_reset();
        n_reset = 1'b0;
        collect_data = 1'b0; data_available = 1'b0; fx3_ready = 1'b0; buffer_error = 1'b0;
        base = 16'($urandom);
        step(2);
        clear_stats();
        n_reset = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        collect_data = 1'b1; data_available = 1'b1; fx3_ready = 1'b1; buffer_error = 1'b1;
        step(3);
        checks++; if (read_data !== 1'b0)     begin errors++; $display("FAIL reset_read_data: got %b want 0", read_data); end
        checks++; if (fx3_write !== 1'b0)     begin errors++; $display("FAIL reset_fx3_write: got %b want 0", fx3_write); end
        checks++; if (fx3_eop !== 1'b0)       begin errors++; $display("FAIL reset_eop: got %b want 0", fx3_eop); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (error_sticky !== 1'b0)  begin errors++; $display("FAIL reset_error_sticky: got %b want 0", error_sticky); end
        checks++; if (packet_count !== 16'd0) begin errors++; $display("FAIL reset_packet_count: got %0d want 0", packet_count); end
        collect_data = 1'b0; data_available = 1'b0; fx3_ready = 1'b0; buffer_error = 1'b0;
        clear_stats();
        n_reset = 1'b1;
        step(5);
        checks++; if (rd_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle_quiet: reads %0d busy %b want 0/0", rd_cnt, busy); end
    endtask

    task automatic test_single_packet();
        int s, t, d;
        apply_reset();
        s = cyc;
        collect_data = 1'b1; fx3_ready = 1'b1;
        d = int'($urandom_range(0, 5));
        wait_until(s + 1 + d);
        data_available = 1'b1;
        t = cyc;
        step();
        data_available = 1'b0;
        wait_until(t + P + L + 5);
        checks++; if (rd_cnt !== P)   begin errors++; $display("FAIL single_read_cycles: got %0d want %0d", rd_cnt, P); end
        checks++; if (wr_cnt !== P)   begin errors++; $display("FAIL single_write_cycles: got %0d want %0d", wr_cnt, P); end
        checks++; if (data_bad !== 0) begin errors++; $display("FAIL single_data_order: %0d bad words, want 0", data_bad); end
        checks++; if (eop_bad !== 0)  begin errors++; $display("FAIL single_eop_place: %0d bad cycles, want 0", eop_bad); end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL single_busy: %0d bad cycles, want 0", busy_bad); end
        checks++; if (at_or(rd_rise, 0) !== t + 1) begin errors++; $display("FAIL single_first_read: got %0d want %0d", at_or(rd_rise, 0), t + 1); end
        checks++; if (at_or(eop_cyc, 0) !== t + P + L || eop_cnt !== 1) begin errors++; $display("FAIL single_eop_cycle: got %0d (count %0d) want %0d (count 1)", at_or(eop_cyc, 0), eop_cnt, t + P + L); end
        checks++; if (at_or(pc_at_eop, 0) !== 0) begin errors++; $display("FAIL single_count_at_eop: got %0d want 0", at_or(pc_at_eop, 0)); end
        checks++; if (packet_count !== 16'd1) begin errors++; $display("FAIL single_packet_count: got %0d want 1", packet_count); end
    endtask

    task automatic test_back_to_back();
        int s, t3;
        apply_reset();
        s = cyc;
        collect_data = 1'b1; fx3_ready = 1'b1; data_available = 1'b1;
        t3 = s + 1 + 3 * (P + L + 1);
        wait_until(t3 + 1);
        data_available = 1'b0;
        wait_until(t3 + P + L + 6);
        checks++; if (rd_rise.size() !== 4) begin errors++; $display("FAIL b2b_burst_count: got %0d want 4", rd_rise.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (at_or(rd_rise, k) !== s + 2 + k * (P + L + 1)) begin
                errors++; $display("FAIL b2b_burst_start[%0d]: got %0d want %0d", k, at_or(rd_rise, k), s + 2 + k * (P + L + 1));
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (at_or(rd_rise, k + 1) - at_or(rd_fall, k) - 1 !== L + 1) begin
                errors++; $display("FAIL b2b_gap[%0d]: got %0d idle cycles want %0d", k, at_or(rd_rise, k + 1) - at_or(rd_fall, k) - 1, L + 1);
            end
        end
        checks++; if (rd_cnt !== 4 * P || wr_cnt !== 4 * P) begin errors++; $display("FAIL b2b_words: reads %0d writes %0d want %0d", rd_cnt, wr_cnt, 4 * P); end
        checks++; if (data_bad !== 0 || eop_bad !== 0 || busy_bad !== 0) begin errors++; $display("FAIL b2b_stream: data %0d eop %0d busy %0d bad, want 0", data_bad, eop_bad, busy_bad); end
        checks++; if (eop_cnt !== 4) begin errors++; $display("FAIL b2b_eop_count: got %0d want 4", eop_cnt); end
        checks++; if (packet_count !== 16'd4) begin errors++; $display("FAIL b2b_packet_count: got %0d want 4", packet_count); end
    endtask

    task automatic test_fx3_ready_gating();
        int s, r;
        apply_reset();
        s = cyc;
        collect_data = 1'b1; data_available = 1'b1; fx3_ready = 1'b0;
        wait_until(s + 101);
        checks++; if (rd_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL gate_no_read: reads %0d busy %b want 0/0", rd_cnt, busy); end
        fx3_ready = 1'b1;
        r = cyc;
        wait_until(r + 1 + int'($urandom_range(10, P - 10)));
        fx3_ready = 1'b0; data_available = 1'b0;
        wait_until(r + P + L + 5);
        checks++; if (at_or(rd_rise, 0) !== r + 1 || rd_rise.size() !== 1) begin errors++; $display("FAIL gate_start: got %0d (bursts %0d) want %0d (1)", at_or(rd_rise, 0), rd_rise.size(), r + 1); end
        checks++; if (rd_cnt !== P || wr_cnt !== P) begin errors++; $display("FAIL gate_words: reads %0d writes %0d want %0d", rd_cnt, wr_cnt, P); end
        checks++; if (data_bad !== 0 || eop_cnt !== 1) begin errors++; $display("FAIL gate_stream: bad %0d eops %0d want 0/1", data_bad, eop_cnt); end
        checks++; if (packet_count !== 16'd1) begin errors++; $display("FAIL gate_packet_count: got %0d want 1", packet_count); end
    endtask

    task automatic test_stop_mid_burst();
        int s, t, e;
        apply_reset();
        s = cyc;
        collect_data = 1'b1; fx3_ready = 1'b1; data_available = 1'b1;
        t = s + 1;
        wait_until(t + 1 + 4000);
        collect_data = 1'b0;
        e = t + P + L;
        wait_until(e + 1);
        collect_data = 1'b1;
        wait_until(e + 5);
        checks++; if (at_or(rd_fall, 0) !== t + P) begin errors++; $display("FAIL stop_last_read: got %0d want %0d", at_or(rd_fall, 0), t + P); end
        checks++; if (at_or(eop_cyc, 0) !== e || eop_cnt !== 1) begin errors++; $display("FAIL stop_eop: got %0d (count %0d) want %0d (1)", at_or(eop_cyc, 0), eop_cnt, e); end
        checks++; if (data_bad !== 0 || eop_bad !== 0 || busy_bad !== 0) begin errors++; $display("FAIL stop_stream: data %0d eop %0d busy %0d bad, want 0", data_bad, eop_bad, busy_bad); end
        checks++; if (packet_count !== 16'd1) begin errors++; $display("FAIL stop_packet_count: got %0d want 1", packet_count); end
        checks++; if (at_or(rd_rise, 1) !== e + 3) begin errors++; $display("FAIL stop_went_idle: restart read at %0d want %0d", at_or(rd_rise, 1), e + 3); end
    endtask

    task automatic test_error_latch();
        int s, t, b, e;
        apply_reset();
        s = cyc;
        collect_data = 1'b1; fx3_ready = 1'b1; data_available = 1'b1;
        t = s + 1;
        b = t + 1 + int'($urandom_range(1, P - 2));
        wait_until(b);
        checks++; if (error_sticky !== 1'b0) begin errors++; $display("FAIL err_before_pulse: got %b want 0", error_sticky); end
        buffer_error = 1'b1;
        step();
        buffer_error = 1'b0;
        checks++; if (error_sticky !== 1'b1) begin errors++; $display("FAIL err_set_next_cycle: got %b want 1", error_sticky); end
        e = t + P + L;
        wait_until(e + 20);
        checks++; if (rd_cnt !== P || eop_cnt !== 1) begin errors++; $display("FAIL err_packet_completes: reads %0d eops %0d want %0d/1", rd_cnt, eop_cnt, P); end
        checks++; if (rd_rise.size() !== 1) begin errors++; $display("FAIL err_no_new_burst: got %0d bursts want 1", rd_rise.size()); end
        checks++; if (packet_count !== 16'd1 || error_sticky !== 1'b1) begin errors++; $display("FAIL err_hold: count %0d sticky %b want 1/1", packet_count, error_sticky); end
        collect_data = 1'b0; buffer_error = 1'b1;
        step();
        checks++; if (error_sticky !== 1'b0) begin errors++; $display("FAIL err_clear_wins: got %b want 0", error_sticky); end
        step();
        checks++; if (error_sticky !== 1'b0) begin errors++; $display("FAIL err_no_set_without_collect: got %b want 0", error_sticky); end
        buffer_error = 1'b0; data_available = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int s, t;
        apply_reset();
        s = cyc;
        collect_data = 1'b1; fx3_ready = 1'b1; data_available = 1'b1;
        t = s + 1;
        wait_until(t + 1 + 100);
        n_reset = 1'b0;
        #1;
        checks++; if (read_data !== 1'b0 || fx3_write !== 1'b0 || fx3_eop !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: read %b write %b eop %b want 0/0/0", read_data, fx3_write, fx3_eop); end
        checks++; if (busy !== 1'b0 || error_sticky !== 1'b0 || packet_count !== 16'd0) begin errors++; $display("FAIL rstmid_status: busy %b err %b count %0d want 0/0/0", busy, error_sticky, packet_count); end
        collect_data = 1'b0; data_available = 1'b0;
        step(3);
        n_reset = 1'b1;
        step(5);
        checks++; if (rd_cnt !== 100 || wr_cnt !== 100 - L) begin errors++; $display("FAIL rstmid_partial: reads %0d writes %0d want 100/%0d", rd_cnt, wr_cnt, 100 - L); end
        checks++; if (eop_cnt !== 0) begin errors++; $display("FAIL rstmid_no_eop: got %0d eops want 0", eop_cnt); end
        checks++; if (read_data !== 1'b0 || packet_count !== 16'd0) begin errors++; $display("FAIL rstmid_after: read %b count %0d want 0/0", read_data, packet_count); end
    endtask

    task automatic test_packet_count_wrap();
        int s, t;
        apply_reset();
        force dut.packet_count = 16'hffff;
        step();
        release dut.packet_count;
        step();
        checks++; if (packet_count !== 16'hffff) begin errors++; $display("FAIL wrap_preset: got %0d want 65535", packet_count); end
        s = cyc;
        collect_data = 1'b1; fx3_ready = 1'b1;
        wait_until(s + 1);
        data_available = 1'b1;
        t = cyc;
        step();
        data_available = 1'b0;
        wait_until(t + P + L + 5);
        checks++; if (at_or(pc_at_eop, 0) !== 65535 || eop_cnt !== 1) begin errors++; $display("FAIL wrap_at_eop: got %0d (eops %0d) want 65535 (1)", at_or(pc_at_eop, 0), eop_cnt); end
        checks++; if (packet_count !== 16'd0) begin errors++; $display("FAIL wrap_packet_count: got %0d want 0", packet_count); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_reset = 1'b0;
        collect_data = 1'b0; data_available = 1'b0; fx3_ready = 1'b0; buffer_error = 1'b0;
        fifo_data = 16'h0000;
        base = 16'h0000;
        clear_stats();
        step();
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_fx3_ready_gating();
        test_stop_mid_burst();
        test_error_latch();
        test_reset_mid_burst();
        test_packet_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
